// File: rtl/bpi_flash_cmd_seq.sv
// rtl/bpi_flash_cmd_seq.sv - CFI command sequencer issuing single-beat AXI accesses to a BPI flash slave
module bpi_flash_cmd_seq #(
    parameter int C_AXI_WIDTH  = 32,
    parameter int C_MEM_WIDTH  = 16,
    parameter int C_MEM_SIZE   = 134217728,
    parameter int C_POLL_LIMIT = 1000000,
    localparam int AW = $clog2(C_MEM_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 cmd_op,
    input  logic [AW-1:0]              cmd_addr,
    input  logic [C_MEM_WIDTH-1:0]     cmd_data,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    output logic [7:0]                 rsp_status,
    output logic                       rsp_error,
    output logic                       rsp_timeout,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [AW-1:0]              m_axi_awaddr,
    output logic [7:0]                 m_axi_awlen,
    output logic [2:0]                 m_axi_awsize,
    output logic [1:0]                 m_axi_awburst,
    output logic                       m_axi_awvalid,
    input  logic                       m_axi_awready,
    output logic [C_AXI_WIDTH-1:0]     m_axi_wdata,
    output logic [C_AXI_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                       m_axi_wlast,
    output logic                       m_axi_wvalid,
    input  logic                       m_axi_wready,
    input  logic [1:0]                 m_axi_bresp,
    input  logic                       m_axi_bvalid,
    output logic                       m_axi_bready,
    output logic [AW-1:0]              m_axi_araddr,
    output logic [7:0]                 m_axi_arlen,
    output logic [2:0]                 m_axi_arsize,
    output logic [1:0]                 m_axi_arburst,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic [C_AXI_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rlast,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready
);

    localparam int NB   = C_AXI_WIDTH / 8;
    localparam int MB   = C_MEM_WIDTH / 8;
    localparam int NL   = C_AXI_WIDTH / C_MEM_WIDTH;
    localparam int LW   = (NL > 1) ? $clog2(NL) : 1;
    localparam int LSB  = $clog2(MB);
    localparam int PW   = $clog2(C_POLL_LIMIT + 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(C_POLL_LIMIT);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WRESP, S_RD, S_RDATA, S_RSP} state_t;
    typedef enum logic [1:0] {K_WR, K_POLL, K_DONE} kind_t;
    typedef struct packed {
        kind_t                  kind;
        logic [C_MEM_WIDTH-1:0] val;
    } step_t;

    // Command scripts: each op is a short list of writes with an optional status poll.
    function automatic step_t step_at(input logic [1:0] op, input logic [2:0] s,
                                      input logic [C_MEM_WIDTH-1:0] d);
        step_t r;
        r.kind = K_DONE;
        r.val  = '0;
        case (op)
            2'd0: if (s == 3'd0) begin r.kind = K_WR; r.val = C_MEM_WIDTH'(16'h00FF); end
            2'd1, 2'd2: begin
                case (s)
                    3'd0: begin r.kind = K_WR; r.val = (op == 2'd1) ? C_MEM_WIDTH'(16'h0040) : C_MEM_WIDTH'(16'h0020); end
                    3'd1: begin r.kind = K_WR; r.val = (op == 2'd1) ? d : C_MEM_WIDTH'(16'h00D0); end
                    3'd2: begin r.kind = K_WR; r.val = C_MEM_WIDTH'(16'h0070); end
                    3'd3: r.kind = K_POLL;
                    3'd4: begin r.kind = K_WR; r.val = C_MEM_WIDTH'(16'h0050); end
                    3'd5: begin r.kind = K_WR; r.val = C_MEM_WIDTH'(16'h00FF); end
                    default: r.kind = K_DONE;
                endcase
            end
            default: begin
                case (s)
                    3'd0: begin r.kind = K_WR; r.val = C_MEM_WIDTH'(16'h0060); end
                    3'd1: begin r.kind = K_WR; r.val = C_MEM_WIDTH'(16'h00D0); end
                    3'd2: begin r.kind = K_WR; r.val = C_MEM_WIDTH'(16'h00FF); end
                    default: r.kind = K_DONE;
                endcase
            end
        endcase
        return r;
    endfunction

    function automatic state_t kind_state(input kind_t k);
        case (k)
            K_WR:    return S_WR;
            K_POLL:  return S_RD;
            default: return S_RSP;
        endcase
    endfunction

    state_t                 state_q, state_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   cfg_q;
    logic [1:0]             op_q, op_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [C_MEM_WIDTH-1:0] data_q, data_d;
    logic [2:0]             step_q, step_d;
    logic [PW-1:0]          poll_q, poll_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;
    logic [7:0]             status_q, status_d;
    logic                   err_q, err_d;
    logic                   tmo_q, tmo_d;

    step_t                  cur, nxt;
    logic [LW-1:0]          lane;
    logic [C_MEM_WIDTH-1:0] rd_word;
    logic [NB-1:0]          strb;
    logic                   unused_bits;

    assign cur     = step_at(op_q, step_q, data_q);
    assign nxt     = step_at(op_q, step_q + 3'd1, data_q);
    assign lane    = (NL > 1) ? addr_q[LSB +: LW] : '0;
    assign rd_word = m_axi_rdata[lane*C_MEM_WIDTH +: C_MEM_WIDTH];
    assign unused_bits = ^{m_axi_rlast, cmd_addr[0], cur.kind, nxt.val, rd_word[C_MEM_WIDTH-1:8]};

    always_comb begin
        strb = '0;
        for (int i = 0; i < NL; i++) begin
            if (lane == LW'(i)) strb[i*MB +: MB] = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            cfg_q       <= 1'b0;
            op_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            step_q      <= '0;
            poll_q      <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            status_q    <= '0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cfg_q       <= 1'b1;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            step_q      <= step_d;
            poll_q      <= poll_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            status_q    <= status_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        step_d    = step_q;
        poll_d    = poll_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        status_d  = status_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        // Drops on the accepting edge so a held cmd_valid is not taken twice.
        cmd_ready_d = (state_q == S_IDLE) && !(cmd_valid && cmd_ready_q);
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d      = cmd_op;
                    addr_d    = {cmd_addr[AW-1:1], 1'b0};
                    data_d    = cmd_data;
                    step_d    = '0;
                    poll_d    = '0;
                    status_d  = '0;
                    err_d     = 1'b0;
                    tmo_d     = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WR;
                end
            end
            S_WR: begin
                aw_done_d = aw_done_q | (m_axi_awvalid & m_axi_awready);
                w_done_d  = w_done_q  | (m_axi_wvalid  & m_axi_wready);
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WRESP;
                end
            end
            S_WRESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_RSP;
                    end else begin
                        step_d  = step_q + 3'd1;
                        state_d = kind_state(nxt.kind);
                    end
                end
            end
            S_RD: begin
                if (m_axi_arready) state_d = S_RDATA;
            end
            S_RDATA: begin
                if (m_axi_rvalid) begin
                    status_d = rd_word[7:0];
                    poll_d   = (poll_q == POLL_MAX) ? poll_q : poll_q + PW'(1);
                    if (m_axi_rresp != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_RSP;
                    end else if (rd_word[7]) begin
                        if (rd_word[5] | rd_word[4] | rd_word[3] | rd_word[1]) err_d = 1'b1;
                        step_d  = step_q + 3'd1;
                        state_d = S_WR;
                    end else if (poll_d == POLL_MAX) begin
                        // Device never went ready: skip the status clear, restore read-array.
                        tmo_d   = 1'b1;
                        step_d  = step_q + 3'd2;
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RSP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = (state_q == S_RSP);
    assign rsp_status    = status_q;
    assign rsp_error     = err_q;
    assign rsp_timeout   = tmo_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = cfg_q ? 3'(LSB) : 3'd0;
    assign m_axi_awburst = cfg_q ? 2'b01 : 2'b00;
    assign m_axi_awvalid = (state_q == S_WR) && !aw_done_q;
    assign m_axi_wvalid  = (state_q == S_WR) && !w_done_q;
    assign m_axi_wdata   = m_axi_wvalid ? {NL{cur.val}} : '0;
    assign m_axi_wstrb   = m_axi_wvalid ? strb : '0;
    assign m_axi_wlast   = cfg_q;
    assign m_axi_bready  = (state_q == S_WRESP);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = cfg_q ? 3'(LSB) : 3'd0;
    assign m_axi_arburst = cfg_q ? 2'b01 : 2'b00;
    assign m_axi_arvalid = (state_q == S_RD);
    assign m_axi_rready  = (state_q == S_RDATA);

endmodule

// File: tb/tb_bpi_flash_cmd_seq.sv
// tb/tb_bpi_flash_cmd_seq.sv - directed bench for bpi_flash_cmd_seq with a reactive AXI flash slave
module tb_bpi_flash_cmd_seq;
    localparam int AW = 27;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [15:0]   cmd_data;
    logic          cmd_valid, cmd_ready;
    logic [7:0]    rsp_status;
    logic          rsp_error, rsp_timeout, rsp_valid, rsp_ready;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;

    bpi_flash_cmd_seq #(.C_AXI_WIDTH(32), .C_MEM_WIDTH(16), .C_MEM_SIZE(134217728), .C_POLL_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rsp_status(rsp_status), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    int checks = 0;
    int errors = 0;

    int            aw_delay = 0;
    int            berr_idx = 0;
    logic [7:0]    st_list[$];
    logic [7:0]    st_default = 8'h00;
    int            st_idx = 0;
    logic [31:0]   wd_q[$];
    logic [3:0]    ws_q[$];
    logic [AW-1:0] wa_q[$];
    logic [AW-1:0] ra_q[$];
    logic [31:0]   ex_q[$];
    int            wr_n = 0;
    int            rsp_cnt = 0;

    // Flash slave: decides ready/valid at negedge, handshakes complete at the following posedge.
    initial begin
        int   aw_wait;
        logic aw_got, w_got, b_pend, r_pend, rsp_prev, rd_lane;
        logic [1:0] bresp_nx;
        logic [7:0] st;
        aw_wait = 0; aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; rsp_prev = 0; rd_lane = 0; bresp_nx = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_wait = 0; aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; rsp_prev = 0;
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            end else begin
                if (rsp_valid && !rsp_prev) rsp_cnt++;
                rsp_prev = rsp_valid;
                if (b_pend && bready) begin bvalid = 1; bresp = bresp_nx; b_pend = 0; end
                else begin bvalid = 0; bresp = 0; end
                if (r_pend && rready) begin
                    st = (st_idx < st_list.size()) ? st_list[st_idx] : st_default;
                    st_idx++;
                    rdata = rd_lane ? {8'h00, st, 16'h007E} : {16'h007E, 8'h00, st};
                    rvalid = 1; r_pend = 0;
                end else rvalid = 0;
                arready = arvalid;
                if (arvalid) begin ra_q.push_back(araddr); rd_lane = araddr[1]; r_pend = 1; end
                if (awvalid) begin
                    if (aw_wait >= aw_delay) begin awready = 1; aw_got = 1; wa_q.push_back(awaddr); end
                    else begin awready = 0; aw_wait++; end
                end else begin awready = 0; aw_wait = 0; end
                wready = wvalid;
                if (wvalid) begin w_got = 1; wd_q.push_back(wdata); ws_q.push_back(wstrb); end
                if (aw_got && w_got) begin
                    aw_got = 0; w_got = 0; wr_n++; b_pend = 1;
                    bresp_nx = (wr_n == berr_idx) ? 2'b10 : 2'b00;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [15:0] d);
        int n;
        wd_q.delete(); ws_q.delete(); wa_q.delete(); ra_q.delete();
        wr_n = 0; st_idx = 0; rsp_cnt = 0; n = 0;
        @(negedge clk);
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
        chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic chk_rsp(input logic [7:0] st, input logic err, input logic tmo);
        chk("rsp_status", {24'd0, rsp_status}, {24'd0, st});
        chk("rsp_error", {31'd0, rsp_error}, {31'd0, err});
        chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, tmo});
    endtask

    task automatic chk_writes(input string tag);
        chk({tag, "_nwr"}, wd_q.size(), ex_q.size());
        for (int i = 0; i < ex_q.size(); i++)
            if (i < wd_q.size()) chk({tag, "_wdata"}, wd_q[i], ex_q[i]);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {21'd0, cmd_ready, rsp_valid, rsp_error, rsp_timeout, awvalid, wvalid, bready,
                            arvalid, rready, wlast, rsp_ready}, 32'd0);
        chk({tag, "_axi"}, {16'd0, awsize, arsize, awburst, arburst, awlen[1:0], arlen[1:0], wstrb}, 32'd0);
        chk({tag, "_wdata"}, wdata, 32'd0);
        chk({tag, "_addr"}, {5'd0, awaddr | araddr}, 32'd0);
        chk({tag, "_status"}, {24'd0, rsp_status}, 32'd0);
    endtask

    initial begin
        cmd_op = 0; cmd_addr = 0; cmd_data = 0; cmd_valid = 0; rsp_ready = 0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 0;
        @(negedge clk);
        chk("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        // PROGRAM with two busy polls
        st_list = '{8'h00, 8'h00, 8'h80};
        do_cmd(2'd1, 27'h1000, 16'hBEEF);
        wait_rsp();
        chk_rsp(8'h80, 1'b0, 1'b0);
        finish_rsp();
        ex_q = '{32'h00400040, 32'hBEEFBEEF, 32'h00700070, 32'h00500050, 32'h00FF00FF};
        ex_q.insert(2, 32'h00700070);
        ex_q.delete(2);
        chk_writes("prog");
        chk("prog_nrd", ra_q.size(), 3);
        if (ra_q.size() > 0) chk("prog_araddr", {5'd0, ra_q[0]}, 32'h1000);
        if (wa_q.size() > 5) chk("prog_awaddr_last", {5'd0, wa_q[5]}, 32'h1000);
        if (ws_q.size() > 0) chk("prog_wstrb", {28'd0, ws_q[0]}, 32'h3);
        chk("prog_rsp_count", rsp_cnt, 1);

        // ERASE, ready with erase-error bit
        st_list = '{8'hA0};
        do_cmd(2'd2, 27'h20000, 16'h0000);
        wait_rsp();
        chk_rsp(8'hA0, 1'b1, 1'b0);
        finish_rsp();
        ex_q = '{32'h00200020, 32'h00D000D0, 32'h00700070, 32'h00500050, 32'h00FF00FF};
        chk_writes("erase");
        chk("erase_nrd", ra_q.size(), 1);
        if (wa_q.size() > 0) chk("erase_awaddr", {5'd0, wa_q[0]}, 32'h20000);

        // poll timeout after exactly 4 reads
        st_list.delete(); st_default = 8'h00;
        do_cmd(2'd1, 27'h2000, 16'h1234);
        wait_rsp();
        chk_rsp(8'h00, 1'b0, 1'b1);
        finish_rsp();
        ex_q = '{32'h00400040, 32'h12341234, 32'h00700070, 32'h00FF00FF};
        chk_writes("tmo");
        chk("tmo_nrd", ra_q.size(), 4);

        // UNLOCK with SLVERR on the first write
        berr_idx = 1;
        do_cmd(2'd3, 27'h3000, 16'h0000);
        wait_rsp();
        chk_rsp(8'h00, 1'b1, 1'b0);
        finish_rsp();
        berr_idx = 0;
        ex_q = '{32'h00600060};
        chk_writes("unlock");
        chk("unlock_nrd", ra_q.size(), 0);

        // upper lane, slow awready, response back-pressure
        aw_delay = 3;
        st_list = '{8'h80};
        do_cmd(2'd1, 27'h0007, 16'hCAFE);
        chk("lane_both_valid", {30'd0, awvalid, wvalid}, 32'h3);
        @(negedge clk);
        chk("lane_aw_held", {30'd0, awvalid, wvalid}, 32'h2);
        @(negedge clk);
        chk("lane_aw_held2", {30'd0, awvalid, wvalid}, 32'h2);
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp", {22'd0, rsp_valid, cmd_ready, rsp_status}, {22'd0, 1'b1, 1'b0, 8'h80});
        end
        chk_rsp(8'h80, 1'b0, 1'b0);
        finish_rsp();
        @(negedge clk);
        chk("lane_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        aw_delay = 0;
        ex_q = '{32'h00400040, 32'hCAFECAFE, 32'h00700070, 32'h00500050, 32'h00FF00FF};
        chk_writes("lane");
        if (ws_q.size() > 0) chk("lane_wstrb", {28'd0, ws_q[0]}, 32'hC);
        if (wa_q.size() > 0) chk("lane_awaddr", {5'd0, wa_q[0]}, 32'h6);

        // reset during ERASE polling, then READ_ARRAY
        st_list.delete();
        do_cmd(2'd2, 27'h40, 16'h0000);
        begin
            int n = 0;
            while (ra_q.size() < 1 && n < 100) begin @(negedge clk); n++; end
            chk("mid_poll_reached", {31'd0, ra_q.size() >= 1}, 32'd1);
        end
        rst = 1;
        #1;
        chk_all_zero("midrst");
        repeat (2) @(negedge clk);
        chk_all_zero("midrst_hold");
        rst = 0;
        @(negedge clk);
        do_cmd(2'd0, 27'h100, 16'h0000);
        wait_rsp();
        chk_rsp(8'h00, 1'b0, 1'b0);
        finish_rsp();
        ex_q = '{32'h00FF00FF};
        chk_writes("rdarr");
        chk("rdarr_nrd", ra_q.size(), 0);
        if (wa_q.size() > 0) chk("rdarr_awaddr", {5'd0, wa_q[0]}, 32'h100);
        chk("rdarr_rsp_count", rsp_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
